// File: rtl/mvdr_pkg.sv
// rtl/mvdr_pkg.sv - shared constants and Q1.15 helpers for the MVDR datapath
package mvdr_pkg;
  localparam int          NCH       = 4;
  localparam int          DW        = 16;
  localparam int          NBINS     = 129;
  localparam logic [15:0] ALPHA_DEF = 16'd31129;
  localparam int          NPAIRS    = 10;

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_DRAIN} seq_state_t;

  // Element index of R[row][col]; the low two bits are the column.
  function automatic logic [3:0] elem_idx(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

  function automatic logic signed [31:0] mul16(input logic signed [15:0] a,
                                               input logic signed [15:0] b);
    return 32'(a) * 32'(b);
  endfunction

  function automatic logic signed [16:0] q15_mul(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
    return 17'(mul16(a, b) >>> 15);
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [19:0] v);
    if (v > 20'sd32767)
      return 16'sh7FFF;
    else if (v < -20'sd32768)
      return 16'sh8000;
    else
      return 16'(v);
  endfunction
endpackage

// File: rtl/cmac_q15.sv
// rtl/cmac_q15.sv - pipelined conjugate multiply with alpha-scaled accumulate
module cmac_q15
  import mvdr_pkg::*;
#(
  parameter logic [15:0] ALPHA = ALPHA_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic signed [15:0] xi_re,
  input  logic signed [15:0] xi_im,
  input  logic signed [15:0] xj_re,
  input  logic signed [15:0] xj_im,
  input  logic signed [15:0] old_re,
  input  logic signed [15:0] old_im,
  output logic               out_valid,
  output logic signed [15:0] new_re,
  output logic signed [15:0] new_im
);
  logic signed [32:0] dot_re, dot_im;
  logic signed [17:0] p_re, p_im;
  logic signed [16:0] a_re, a_im;
  logic               mid_valid;

  // xi * conj(xj), kept at full precision until the floor shift
  always_comb begin
    dot_re = 33'(mul16(xi_re, xj_re)) + 33'(mul16(xi_im, xj_im));
    dot_im = 33'(mul16(xi_im, xj_re)) - 33'(mul16(xi_re, xj_im));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mid_valid <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      mid_valid <= in_valid;
      out_valid <= mid_valid;
    end
    p_re   <= 18'(dot_re >>> 15);
    p_im   <= 18'(dot_im >>> 15);
    a_re   <= q15_mul(ALPHA, old_re);
    a_im   <= q15_mul(ALPHA, old_im);
    new_re <= sat16(20'(p_re) + 20'(a_re));
    new_im <= sat16(20'(p_im) + 20'(a_im));
  end
endmodule

// File: rtl/covariance_est.sv
// rtl/covariance_est.sv - recursive 4x4 Hermitian covariance estimator per bin
module covariance_est #(
  parameter int          NBINS = mvdr_pkg::NBINS,
  parameter int          DW    = mvdr_pkg::DW,
  parameter logic [15:0] ALPHA = mvdr_pkg::ALPHA_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] x0_re,
  input  logic signed [DW-1:0] x0_im,
  input  logic signed [DW-1:0] x1_re,
  input  logic signed [DW-1:0] x1_im,
  input  logic signed [DW-1:0] x2_re,
  input  logic signed [DW-1:0] x2_im,
  input  logic signed [DW-1:0] x3_re,
  input  logic signed [DW-1:0] x3_im,
  input  logic [7:0]           x_bin,
  input  logic                 x_valid,
  input  logic [7:0]           rd_bin,
  input  logic [3:0]           rd_elem,
  input  logic                 rd_en,
  output logic signed [DW-1:0] rd_re,
  output logic signed [DW-1:0] rd_im,
  output logic                 rd_valid
);
  import mvdr_pkg::*;

  localparam int         DEPTH     = NBINS * 16;
  localparam logic [7:0] BIN_LIM   = 8'(NBINS - 1);
  localparam logic [3:0] LAST_PAIR = 4'(NPAIRS - 1);

  seq_state_t state, state_nx;
  logic [3:0] cnt;
  logic       accept, issue;

  logic [7:0]           lbin;
  logic                 lvalid;
  logic signed [DW-1:0] lx_re [NCH];
  logic signed [DW-1:0] lx_im [NCH];

  logic [NBINS-1:0]     bin_valid;
  logic signed [DW-1:0] mem_re [DEPTH];
  logic signed [DW-1:0] mem_im [DEPTH];

  logic [3:0]           pair_elem;
  logic [11:0]          upd_addr, rd_addr;
  logic                 s1_valid, s1_last, s2_last, wr_last;
  logic [3:0]           s1_elem, s2_elem, wr_elem, mirror_elem;
  logic signed [DW-1:0] s1_xi_re, s1_xi_im, s1_xj_re, s1_xj_im, s1_old_re, s1_old_im;
  logic                 wr_valid, wr_diag, rd_hit;
  logic signed [DW-1:0] wr_re, wr_im, neg_im;

  always_ff @(posedge clk) begin
    if (rst) state <= SEQ_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      SEQ_IDLE:  if (accept) state_nx = SEQ_RUN;
      SEQ_RUN:   if (cnt == LAST_PAIR) state_nx = SEQ_DRAIN;
      SEQ_DRAIN: if (wr_valid && wr_last) state_nx = SEQ_IDLE;
      default:   state_nx = SEQ_IDLE;
    endcase
  end

  always_comb begin
    accept = x_valid && (state == SEQ_IDLE) && (x_bin <= BIN_LIM);
    issue  = (state == SEQ_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst)         cnt <= 4'd0;
    else if (accept) cnt <= 4'd0;
    else if (issue)  cnt <= cnt + 4'd1;
  end

  // Snapshot and the bin's history flag are frozen for the whole update
  always_ff @(posedge clk) begin
    if (accept) begin
      lbin     <= x_bin;
      lvalid   <= bin_valid[x_bin];
      lx_re[0] <= x0_re;  lx_im[0] <= x0_im;
      lx_re[1] <= x1_re;  lx_im[1] <= x1_im;
      lx_re[2] <= x2_re;  lx_im[2] <= x2_im;
      lx_re[3] <= x3_re;  lx_im[3] <= x3_im;
    end
  end

  // Upper-triangle pair ROM, entries are elem_idx(i, j) with i <= j
  always_comb begin
    case (cnt)
      4'd0:    pair_elem = elem_idx(2'd0, 2'd0);
      4'd1:    pair_elem = elem_idx(2'd0, 2'd1);
      4'd2:    pair_elem = elem_idx(2'd0, 2'd2);
      4'd3:    pair_elem = elem_idx(2'd0, 2'd3);
      4'd4:    pair_elem = elem_idx(2'd1, 2'd1);
      4'd5:    pair_elem = elem_idx(2'd1, 2'd2);
      4'd6:    pair_elem = elem_idx(2'd1, 2'd3);
      4'd7:    pair_elem = elem_idx(2'd2, 2'd2);
      4'd8:    pair_elem = elem_idx(2'd2, 2'd3);
      default: pair_elem = elem_idx(2'd3, 2'd3);
    endcase
  end

  assign upd_addr = {lbin, pair_elem};

  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else     s1_valid <= issue;
    s1_elem   <= pair_elem;
    s1_last   <= (cnt == LAST_PAIR);
    s1_xi_re  <= lx_re[pair_elem[3:2]];
    s1_xi_im  <= lx_im[pair_elem[3:2]];
    s1_xj_re  <= lx_re[pair_elem[1:0]];
    s1_xj_im  <= lx_im[pair_elem[1:0]];
    s1_old_re <= lvalid ? mem_re[upd_addr] : '0;
    s1_old_im <= lvalid ? mem_im[upd_addr] : '0;
  end

  cmac_q15 #(.ALPHA(ALPHA)) u_cmac (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .xi_re     (s1_xi_re),
    .xi_im     (s1_xi_im),
    .xj_re     (s1_xj_re),
    .xj_im     (s1_xj_im),
    .old_re    (s1_old_re),
    .old_im    (s1_old_im),
    .out_valid (wr_valid),
    .new_re    (wr_re),
    .new_im    (wr_im)
  );

  always_ff @(posedge clk) begin
    s2_elem <= s1_elem;
    s2_last <= s1_last;
    wr_elem <= s2_elem;
    wr_last <= s2_last;
  end

  always_comb begin
    mirror_elem = {wr_elem[1:0], wr_elem[3:2]};
    wr_diag     = (wr_elem[3:2] == wr_elem[1:0]);
    neg_im      = (wr_im == 16'sh8000) ? 16'sh7FFF : -wr_im;
  end

  // The write port updates an element and its conjugate mirror together
  always_ff @(posedge clk) begin
    if (wr_valid && !rst) begin
      mem_re[{lbin, wr_elem}] <= wr_re;
      mem_im[{lbin, wr_elem}] <= wr_im;
      if (!wr_diag) begin
        mem_re[{lbin, mirror_elem}] <= wr_re;
        mem_im[{lbin, mirror_elem}] <= neg_im;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                      bin_valid <= '0;
    else if (wr_valid && wr_last) bin_valid[lbin] <= 1'b1;
  end

  assign rd_addr = {rd_bin, rd_elem};
  assign rd_hit  = (rd_bin <= BIN_LIM) && bin_valid[rd_bin];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_re    <= '0;
      rd_im    <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_re <= rd_hit ? mem_re[rd_addr] : '0;
        rd_im <= rd_hit ? mem_im[rd_addr] : '0;
      end
    end
  end
endmodule

// File: tb/tb_covariance_est.sv
// tb/tb_covariance_est.sv - randomized scoreboard bench for covariance_est
module tb_covariance_est;
  localparam int NB    = 129;
  localparam int ALPHA = 31129;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [15:0] x0_re = '0, x0_im = '0, x1_re = '0, x1_im = '0;
  logic signed [15:0] x2_re = '0, x2_im = '0, x3_re = '0, x3_im = '0;
  logic [7:0]  x_bin = '0;
  logic        x_valid = 1'b0;
  logic [7:0]  rd_bin = '0;
  logic [3:0]  rd_elem = '0;
  logic        rd_en = 1'b0;
  logic signed [15:0] rd_re, rd_im;
  logic        rd_valid;

  always #5 clk = ~clk;

  covariance_est dut (
    .clk(clk), .rst(rst),
    .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im),
    .x2_re(x2_re), .x2_im(x2_im), .x3_re(x3_re), .x3_im(x3_im),
    .x_bin(x_bin), .x_valid(x_valid),
    .rd_bin(rd_bin), .rd_elem(rd_elem), .rd_en(rd_en),
    .rd_re(rd_re), .rd_im(rd_im), .rd_valid(rd_valid)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mr [NB][16];
  int mi [NB][16];
  bit mv [NB];
  int sx_re [4];
  int sx_im [4];
  int q_re [$];
  int q_im [$];
  int q_cyc [$];
  int q_tag [$];
  int rd_seq = 0;

  always @(posedge clk) cyc++;

  function automatic int sat(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // R = alpha*R + x*x^H, lower triangle as conjugate of the upper one
  task automatic model_update(int b);
    longint ore, oim, pre, pim;
    int nre, nim;
    for (int i = 0; i < 4; i++)
      for (int j = i; j < 4; j++) begin
        ore = mv[b] ? longint'(mr[b][i*4+j]) : 0;
        oim = mv[b] ? longint'(mi[b][i*4+j]) : 0;
        pre = (longint'(sx_re[i]) * sx_re[j] + longint'(sx_im[i]) * sx_im[j]) >>> 15;
        pim = (longint'(sx_im[i]) * sx_re[j] - longint'(sx_re[i]) * sx_im[j]) >>> 15;
        nre = sat(((ALPHA * ore) >>> 15) + pre);
        nim = sat(((ALPHA * oim) >>> 15) + pim);
        mr[b][i*4+j] = nre;
        mi[b][i*4+j] = nim;
        if (i != j) begin
          mr[b][j*4+i] = nre;
          mi[b][j*4+i] = sat(-longint'(nim));
        end
      end
    mv[b] = 1'b1;
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_sx();
    for (int i = 0; i < 4; i++) begin
      sx_re[i] = 0;
      sx_im[i] = 0;
    end
  endtask

  task automatic rand_sx();
    for (int i = 0; i < 4; i++) begin
      sx_re[i] = $signed(16'($urandom));
      sx_im[i] = $signed(16'($urandom));
    end
  endtask

  task automatic snap(int b, bit accepted);
    x0_re = 16'(sx_re[0]); x0_im = 16'(sx_im[0]);
    x1_re = 16'(sx_re[1]); x1_im = 16'(sx_im[1]);
    x2_re = 16'(sx_re[2]); x2_im = 16'(sx_im[2]);
    x3_re = 16'(sx_re[3]); x3_im = 16'(sx_im[3]);
    x_bin = 8'(b);
    x_valid = 1'b1;
    tick(1);
    x_valid = 1'b0;
    if (accepted) model_update(b);
  endtask

  task automatic rd_issue(int b, int e, int re, int im);
    q_re.push_back(re);
    q_im.push_back(im);
    q_cyc.push_back(cyc + 1);
    q_tag.push_back(b * 16 + e);
    rd_bin = 8'(b);
    rd_elem = 4'(e);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic rd(int b, int e);
    if (b >= NB || !mv[b]) rd_issue(b, e, 0, 0);
    else rd_issue(b, e, mr[b][e], mi[b][e]);
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      checks++;
      if (q_re.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got re=%0d im=%0d want no rd_valid", rd_re, rd_im);
      end else begin
        int er, ei, ec, et;
        er = q_re.pop_front();
        ei = q_im.pop_front();
        ec = q_cyc.pop_front();
        et = q_tag.pop_front();
        if (int'(rd_re) != er || int'(rd_im) != ei || cyc != ec) begin
          errors++;
          $display("FAIL rd bin%0d elem%0d got re=%0d im=%0d cyc=%0d want re=%0d im=%0d cyc=%0d",
                   et / 16, et % 16, rd_re, rd_im, cyc, er, ei, ec);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int b;
    for (int k = 0; k < NB; k++) mv[k] = 1'b0;
    clear_sx();
    tick(3);
    rst = 1'b0;
    chk("reset_rd_valid", int'(rd_valid), 0);
    chk("reset_rd_re", int'(rd_re), 0);
    chk("reset_rd_im", int'(rd_im), 0);
    rd_issue(0, 0, 0, 0);
    rd_issue(128, 15, 0, 0);

    sx_re[0] = 8192;
    snap(0, 1);
    tick(25);
    rd_issue(0, 0, 2048, 0);
    snap(0, 1);
    tick(20);
    rd_issue(0, 0, 3993, 0);
    rd_issue(0, 5, 0, 0);

    clear_sx();
    sx_re[0] = 8192;
    sx_im[1] = 8192;
    snap(1, 1);
    tick(2);
    rand_sx();
    snap(3, 0);
    tick(20);
    rd_issue(1, 1, 0, -2048);
    rd_issue(1, 4, 0, 2048);
    rd_issue(1, 0, 2048, 0);
    rd_issue(1, 5, 2048, 0);
    rd_issue(3, 0, 0, 0);
    rd_issue(200, 0, 0, 0);

    for (int i = 0; i < 4; i++) begin
      sx_re[i] = 32767;
      sx_im[i] = 32767;
    end
    for (int n = 0; n < 30; n++) begin
      snap(2, 1);
      tick(16);
      if (n == 0) rd_issue(2, 0, 32767, 0);
    end
    rd_issue(2, 0, 32767, 0);
    rd_issue(2, 1, 32767, 0);
    for (int e = 0; e < 16; e++) rd(2, e);

    rand_sx();
    snap(200, 0);
    snap(6, 1);
    tick(20);
    for (int e = 0; e < 16; e++) rd(6, e);

    for (int n = 0; n < 40; n++) begin
      b = $urandom_range(0, 9);
      rand_sx();
      snap(b, 1);
      tick(16);
      for (int r = 0; r < 3; r++) rd($urandom_range(0, 12), $urandom_range(0, 15));
      if (n % 8 == 0)
        for (int e = 0; e < 16; e++) rd(b, e);
      tick($urandom_range(0, 2));
    end
    rd(255, 3);

    clear_sx();
    sx_re[0] = 8192;
    snap(5, 1);
    tick(20);
    rd(5, 0);
    snap(5, 0);
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int k = 0; k < NB; k++) mv[k] = 1'b0;
    chk("midrst_rd_valid", int'(rd_valid), 0);
    chk("midrst_rd_re", int'(rd_re), 0);
    rd_issue(5, 0, 0, 0);
    rd_issue(0, 0, 0, 0);
    rd_issue(1, 4, 0, 0);
    rd_issue(2, 0, 0, 0);
    snap(5, 1);
    tick(16);
    rd_issue(5, 0, 2048, 0);
    rd_issue(5, 1, 0, 0);
    for (int e = 0; e < 16; e++) rd(5, e);

    tick(5);
    chk("pending_reads", q_re.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/covariance_est.md
# covariance_est

Recursive spatial covariance estimator for a 4-element array in the MVDR beamformer datapath. Per frequency bin it maintains the 4×4 complex Hermitian matrix R[k] = α·R[k] + x·xᴴ in Q1.15, updated from one STFT snapshot at a time. A registered random-access read port lets the downstream weight solver fetch single matrix elements.

## Interface
Parameters:
- `NBINS`, 129: number of frequency bins stored.
- `DW`, 16: sample and matrix word width, signed Q1.15.
- `ALPHA`, 16'd31129: forgetting factor α in Q1.15 (≈0.95).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `x0_re`,`x0_im` … `x3_re`,`x3_im`  in  DW each  signed snapshot of elements 0..3 for one bin.
- `x_bin`  in  8  bin index of the snapshot.
- `x_valid`  in  1  one-cycle strobe; snapshot and `x_bin` are sampled on this edge.
- `rd_bin`  in  8  bin to read.
- `rd_elem`  in  4  element index = row·4 + col.
- `rd_en`  in  1  read request.
- `rd_re`,`rd_im`  out  DW  signed R[rd_bin][row][col].
- `rd_valid`  out  1  one-cycle pulse marking new read data.

## Operation
- Storage: NBINS×16 complex words, addressed as bin·16 + elem. All 16 elements are stored explicitly; the lower triangle is written with the conjugate of the computed upper-triangle element.
- Per-bin valid bit array (NBINS bits), cleared by `rst`. While a bin's bit is clear, its old R reads as 0 for both the update and the read port. The first update sets the bit. No RAM clear sweep is performed.
- On accepted `x_valid`:
  - Latch all eight inputs and `x_bin`.
  - Sequence the 10 pairs (i ≤ j).
  - For each pair, form P = xi·conj(xj):
    - P_re = (xi_re·xj_re + xi_im·xj_im) >>> 15
    - P_im = (xi_im·xj_re − xi_re·xj_im) >>> 15
    - Use full-precision 2·DW+1 sums and an arithmetic (floor) shift.
  - New value = sat_DW((α·old_re) >>> 15 + P_re), and the same for im. Saturate to ±(2^(DW−1)−1 / −2^(DW−1)).
  - Write the result to (i,j). When i ≠ j, also write (re, −im) to (j,i). Negating −32768 saturates to +32767.
  - The diagonal imag part is computed normally, and is 0 for exact inputs.
- `x_valid` is ignored while an update is in progress, and also when `x_bin` ≥ NBINS.
- Read port:
  - `rd_en` is sampled at a rising edge. On the next edge, `rd_re`/`rd_im` are loaded and `rd_valid` pulses for one cycle.
  - Outputs hold their value until the next read.
  - `rd_bin` ≥ NBINS returns 0,0, with `rd_valid` still pulsing.
- Read/write collision on the same address in the same cycle returns the old (pre-write) value.

## Timing
- Reset values: `rd_re`=0, `rd_im`=0, `rd_valid`=0, valid bits all 0, sequencer IDLE. Reset mid-update aborts the update, and that bin reads as zero afterwards.
- Sequencer states:
  - IDLE: on accepted `x_valid`, go to RUN.
  - RUN: one pair per cycle, pipelined as read-old → multiply → add/saturate → write. Go to DRAIN after the last pair issues.
  - DRAIN: return to IDLE after the last write.
- Update latency: ≤ 16 cycles from the `x_valid` edge to the final write. After that, every element of the bin reads the new value.
- Read latency: exactly 1 cycle. Back-to-back `rd_en` gives one result per cycle.
- A read issued during an update of the same bin may return a mix of old and new elements. The consumer waits for the update latency before reading.

## Structure
- Shared package (`mvdr_pkg`) holds:
  - constants NCH=4, DW, NBINS, default ALPHA;
  - functions `q15_mul` (product >>> 15) and `sat16`;
  - the elem-index encoding row·4+col.
- Natural sub-module: `cmac_q15`, a pipelined conjugate multiply with α-scaled accumulate and saturation. It takes xi, xj and old R, and produces the new R.
- Top-level contents: sequencer FSM, pair-index ROM (10 entries), storage RAM (1 write port, 2 read ports), valid-bit array, read register.

## Test plan
- Reset, then `x_valid` on bin 0 with X0=8192+0j and others 0. After 25 cycles, read elem 0 → re=2048, im=0 (±2).
- Repeat the same snapshot on bin 0. Read elem 0 → re = (31129·2048>>>15) + 2048 = 3993, im=0.
- Bin 1 with X0=8192, X1=0+8192j. Read elem 1 → (0, −2048). Read elem 4 → (0, +2048), confirming Hermitian symmetry.
- Bin 2 with all four X = 32767+32767j, repeated 30 times. R[0][0].re saturates at 32767 and never wraps negative.
- Issue `x_valid` on bin 3 while the bin-1 update is running. The bin-3 snapshot is ignored, so a read of bin 3 elem 0 → 0. A read of `rd_bin`=200 → 0 with `rd_valid` pulsing.
- Assert `rst` mid-update on bin 5. All bins then read 0, and the next bin-5 update equals the first-frame value only (no α-decayed history).
